// File: rtl/dmx8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmx8_pkg
// Purpose  : Shared constants and types for the dmx8_tdm demultiplexer.
//            Frame geometry (slot count / slot index width), the framing
//            state enum and the width of the optional error counter.
// Revision : 1.0  initial release
// ============================================================================
package dmx8_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;
  localparam int ERRCNT_W  = 8;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dmx8_slot_dec.sv
`default_nettype none
// ============================================================================
// Module   : dmx8_slot_dec
// Purpose  : 3-to-8 one-hot decoder of the receive slot counter, gated by a
//            write enable. Produces the per-lane write strobes; it is the
//            receive-side mirror of the transmit mux select tree.
// Ports    : slot_i     - current slot index
//            we_i       - sample accepted into the frame this cycle
//            lane_we_o  - one-hot lane write strobe (all zero when !we_i)
// Revision : 1.0  initial release
// ============================================================================
module dmx8_slot_dec
  import dmx8_pkg::*;
(
  input  logic [SLOT_W-1:0]    slot_i,
  input  logic                 we_i,
  output logic [NUM_SLOTS-1:0] lane_we_o
);

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_dec
    assign lane_we_o[k] = we_i && (slot_i == SLOT_W'(k));
  end

endmodule
`default_nettype wire

// File: rtl/dmx8_tdm.sv
`default_nettype none
// ============================================================================
// Module   : dmx8_tdm
// Purpose  : 8-slot time-division demultiplexer. Collects an interleaved
//            sample stream (slot 0 marked by sync) into shadow lanes and
//            publishes a registered 8-lane parallel word once per complete
//            frame. Framing violations pulse frame_err and either resync
//            (early sync) or drop back to hunting (missing sync).
// Ports    : clk       - clock, rising edge
//            reset_n   - asynchronous active-low reset
//            d_in      - serial sample for the current slot
//            in_valid  - d_in valid this cycle (always consumed)
//            sync      - current sample is slot 0
//            y         - parallel frame, lane k at y[k*WIDTH +: WIDTH]
//            out_valid - one-cycle pulse when y takes a new frame
//            frame_err - one-cycle pulse after a framing violation
//            locked    - high while in RUN
//            err_cnt   - saturating frame_err count (DMX8_ERRCNT_EN only)
// Config   : DMX8_ERRCNT_EN - adds the err_cnt port and its counter
// Revision : 1.0  initial release
// ============================================================================
module dmx8_tdm
  import dmx8_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           d_in,
  input  logic                       in_valid,
  input  logic                       sync,
  output logic [NUM_SLOTS*WIDTH-1:0] y,
  output logic                       out_valid,
  output logic                       frame_err,
  output logic                       locked
`ifdef DMX8_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]        err_cnt
`endif
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  state_e                     state_q, state_d;
  logic [SLOT_W-1:0]          slot_q, slot_d;
  logic [SLOT_W-1:0]          wr_slot;
  logic                       wr_en;
  logic                       err_d;
  logic [NUM_SLOTS-1:0]       lane_we;
  logic [WIDTH-1:0]           shadow_q [NUM_SLOTS-1];
  logic [NUM_SLOTS*WIDTH-1:0] frame_w;
  logic [NUM_SLOTS*WIDTH-1:0] y_q;
  logic                       out_valid_q;
  logic                       frame_err_q;

  // Framing FSM / slot counter next-state. Every sample that joins a frame
  // raises wr_en; the decoded strobe for the last slot doubles as the
  // frame-complete event, so lane 7 needs no shadow storage.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    wr_en   = 1'b0;
    wr_slot = slot_q;
    err_d   = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            wr_en   = 1'b1;
            wr_slot = '0;
            slot_d  = SLOT_W'(1);
            state_d = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // Early sync restarts the frame from this sample.
            err_d   = (slot_q != '0);
            wr_en   = 1'b1;
            wr_slot = '0;
            slot_d  = SLOT_W'(1);
          end else if (slot_q == '0) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            wr_en   = 1'b1;
            slot_d  = slot_q + SLOT_W'(1);  // wraps 7 -> 0
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  dmx8_slot_dec u_slot_dec (
    .slot_i    (wr_slot),
    .we_i      (wr_en),
    .lane_we_o (lane_we)
  );

  for (genvar k = 0; k < NUM_SLOTS - 1; k++) begin : g_lane
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        shadow_q[k] <= '0;
      end else if (lane_we[k]) begin
        shadow_q[k] <= d_in;
      end
    end
    assign frame_w[k*WIDTH +: WIDTH] = shadow_q[k];
  end

  // The final slot is taken straight from the input so y lands on the same
  // edge that accepts the slot-7 sample.
  assign frame_w[(NUM_SLOTS-1)*WIDTH +: WIDTH] = d_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      slot_q      <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      out_valid_q <= lane_we[NUM_SLOTS-1];
      frame_err_q <= err_d;
      if (lane_we[NUM_SLOTS-1]) begin
        y_q <= frame_w;
      end
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign locked    = (state_q == RUN);

`ifdef DMX8_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  // Error counter not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmx8_tdm.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmx8_tdm
// Purpose  : Directed self-checking bench for dmx8_tdm with WIDTH=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmx8_tdm;

  logic        clk;
  logic        reset_n;
  logic [3:0]  d_in;
  logic        in_valid;
  logic        sync;
  logic [31:0] y;
  logic        out_valid;
  logic        frame_err;
  logic        locked;
`ifdef DMX8_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int total_cnt  = 0;
  int passed_cnt = 0;
  int ov_cnt     = 0;
  int fe_cnt     = 0;
  int both_cnt   = 0;

  dmx8_tdm #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .d_in      (d_in),
    .in_valid  (in_valid),
    .sync      (sync),
    .y         (y),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .locked    (locked)
`ifdef DMX8_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1) ov_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
    if (out_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
  end

  task automatic send(input logic s, input logic [3:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    sync     = s;
    d_in     = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      sync     = 1'b0;
    end
  endtask

  task automatic settle();
    idle(1);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0;
    sync     = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++; if (y !== 32'h0) $display("FAIL reset_y: got %h want %h", y, 32'h0); else passed_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_ov: got %b want 0", out_valid); else passed_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_fe: got %b want 0", frame_err); else passed_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else passed_cnt++;
`ifdef DMX8_ERRCNT_EN
    total_cnt++; if (err_cnt !== 8'd0) $display("FAIL reset_errcnt: got %0d want 0", err_cnt); else passed_cnt++;
`endif
  endtask

  task automatic test_clean_frame();
    int ov0, fe0;
    ov0 = ov_cnt; fe0 = fe_cnt;
    send(1'b1, 4'h1);
    for (int k = 2; k <= 8; k++) send(1'b0, 4'(k));
    settle();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL clean_ov_timing: got %b want 1", out_valid); else passed_cnt++;
    total_cnt++; if (y !== 32'h87654321) $display("FAIL clean_y: got %h want %h", y, 32'h87654321); else passed_cnt++;
    total_cnt++; if (locked !== 1'b1) $display("FAIL clean_locked: got %b want 1", locked); else passed_cnt++;
    settle();
    total_cnt++; if (ov_cnt - ov0 !== 1) $display("FAIL clean_ov_count: got %0d want 1", ov_cnt - ov0); else passed_cnt++;
    total_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL clean_fe_count: got %0d want 0", fe_cnt - fe0); else passed_cnt++;
  endtask

  task automatic test_pre_sync();
    int ov0, fe0;
    apply_reset();
    ov0 = ov_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 5; i++) send(1'b0, 4'hF);
    settle();
    total_cnt++; if (locked !== 1'b0) $display("FAIL presync_locked: got %b want 0", locked); else passed_cnt++;
    send(1'b1, 4'h0);
    for (int k = 1; k < 8; k++) send(1'b0, 4'(k));
    settle();
    settle();
    total_cnt++; if (y !== 32'h76543210) $display("FAIL presync_y: got %h want %h", y, 32'h76543210); else passed_cnt++;
    total_cnt++; if (ov_cnt - ov0 !== 1) $display("FAIL presync_ov_count: got %0d want 1", ov_cnt - ov0); else passed_cnt++;
    total_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL presync_fe_count: got %0d want 0", fe_cnt - fe0); else passed_cnt++;
  endtask

  task automatic test_early_sync();
    int ov0, fe0;
    ov0 = ov_cnt; fe0 = fe_cnt;
    send(1'b1, 4'h1);
    send(1'b0, 4'h2);
    send(1'b0, 4'h3);
    send(1'b1, 4'hA);
    send(1'b0, 4'hB);
    #1;
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL early_fe_timing: got %b want 1", frame_err); else passed_cnt++;
    total_cnt++; if (y !== 32'h76543210) $display("FAIL early_y_held: got %h want %h", y, 32'h76543210); else passed_cnt++;
    for (int i = 0; i < 6; i++) send(1'b0, 4'hB);
    settle();
    settle();
    total_cnt++; if (y !== 32'hBBBBBBBA) $display("FAIL early_y: got %h want %h", y, 32'hBBBBBBBA); else passed_cnt++;
    total_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL early_fe_count: got %0d want 1", fe_cnt - fe0); else passed_cnt++;
    total_cnt++; if (ov_cnt - ov0 !== 1) $display("FAIL early_ov_count: got %0d want 1", ov_cnt - ov0); else passed_cnt++;
  endtask

  task automatic test_missing_sync();
    int ov0;
    ov0 = ov_cnt;
    send(1'b0, 4'h5);
    settle();
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL miss_fe: got %b want 1", frame_err); else passed_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL miss_locked: got %b want 0", locked); else passed_cnt++;
    total_cnt++; if (y !== 32'hBBBBBBBA) $display("FAIL miss_y: got %h want %h", y, 32'hBBBBBBBA); else passed_cnt++;
    total_cnt++; if (ov_cnt - ov0 !== 0) $display("FAIL miss_ov_count: got %0d want 0", ov_cnt - ov0); else passed_cnt++;
  endtask

  task automatic test_gaps();
    int ov0;
    ov0 = ov_cnt;
    send(1'b1, 4'h1);
    send(1'b0, 4'h2);
    send(1'b0, 4'h3);
    idle(3);
    for (int k = 4; k <= 7; k++) send(1'b0, 4'(k));
    idle(3);
    #1;
    total_cnt++; if (ov_cnt - ov0 !== 0) $display("FAIL gaps_early_ov: got %0d want 0", ov_cnt - ov0); else passed_cnt++;
    send(1'b0, 4'h8);
    settle();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL gaps_ov_timing: got %b want 1", out_valid); else passed_cnt++;
    total_cnt++; if (y !== 32'h87654321) $display("FAIL gaps_y: got %h want %h", y, 32'h87654321); else passed_cnt++;
  endtask

  task automatic test_back_to_back();
    int ov0;
    settle();
    ov0 = ov_cnt;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) send(i == 0, 4'(i + 8));
      else       send(i == 8, 4'(15 - i));
      if (i == 8) begin
        #1;
        total_cnt++; if (out_valid !== 1'b1 || y !== 32'hFEDCBA98) $display("FAIL b2b_first: got ov=%b y=%h want ov=1 y=%h", out_valid, y, 32'hFEDCBA98); else passed_cnt++;
      end
      if (i == 9) begin
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_ov_pulse: got %b want 0", out_valid); else passed_cnt++;
      end
    end
    settle();
    total_cnt++; if (y !== 32'h01234567) $display("FAIL b2b_second_y: got %h want %h", y, 32'h01234567); else passed_cnt++;
    settle();
    total_cnt++; if (ov_cnt - ov0 !== 2) $display("FAIL b2b_ov_count: got %0d want 2", ov_cnt - ov0); else passed_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int ov0;
    send(1'b1, 4'h1);
    for (int k = 2; k <= 5; k++) send(1'b0, 4'(k));
    #3;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (y !== 32'h0) $display("FAIL rstmid_y: got %h want %h", y, 32'h0); else passed_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL rstmid_locked: got %b want 0", locked); else passed_cnt++;
    total_cnt++; if (out_valid !== 1'b0 || frame_err !== 1'b0) $display("FAIL rstmid_pulses: got ov=%b fe=%b want 0 0", out_valid, frame_err); else passed_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    ov0 = ov_cnt;
    send(1'b0, 4'h3);
    send(1'b0, 4'h3);
    settle();
    total_cnt++; if (locked !== 1'b0) $display("FAIL rstmid_hunt: got %b want 0", locked); else passed_cnt++;
    send(1'b1, 4'h9);
    for (int k = 10; k <= 16; k++) send(1'b0, 4'(k));
    settle();
    total_cnt++; if (y !== 32'h0FEDCBA9) $display("FAIL rstmid_next_y: got %h want %h", y, 32'h0FEDCBA9); else passed_cnt++;
    settle();
    total_cnt++; if (ov_cnt - ov0 !== 1) $display("FAIL rstmid_ov_count: got %0d want 1", ov_cnt - ov0); else passed_cnt++;
  endtask

`ifdef DMX8_ERRCNT_EN
  task automatic test_errcnt_saturate();
    apply_reset();
    send(1'b1, 4'h0);
    for (int i = 0; i < 300; i++) send(1'b1, 4'h0);
    settle();
    settle();
    total_cnt++; if (err_cnt !== 8'd255) $display("FAIL errcnt_sat: got %0d want 255", err_cnt); else passed_cnt++;
  endtask
`endif

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    sync     = 1'b0;
    d_in     = 4'h0;
    test_reset();
    test_clean_frame();
    test_pre_sync();
    test_early_sync();
    test_missing_sync();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef DMX8_ERRCNT_EN
    test_errcnt_saturate();
`endif
    settle();
    total_cnt++; if (both_cnt !== 0) $display("FAIL ov_fe_overlap: got %0d want 0", both_cnt); else passed_cnt++;
    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmx8_tdm.md
# dmx8_tdm

Time-division demultiplexer and the receiving end of the 8-slot serial path. The transmit end is an 8:1 mux driven by a slot counter. This block takes the interleaved sample stream plus a frame-start marker and steers each sample into one of eight lanes. It presents all eight lanes together as a registered parallel word, with a one-cycle valid strobe per completed frame. It sits between the serial link and the 8-lane ALU operand registers.

## Interface
Parameters:
- WIDTH, 1, bits per sample and per output lane.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- d_in  input  WIDTH  serial sample for the current slot.
- in_valid  input  1  d_in is valid this cycle; no backpressure, so a valid sample is always consumed.
- sync  input  1  marks the current sample as slot 0; only meaningful when in_valid=1.
- y  output  8*WIDTH  parallel frame; lane k is y[k*WIDTH +: WIDTH]; reset 0.
- out_valid  output  1  one-cycle pulse when y is updated with a new complete frame; reset 0.
- frame_err  output  1  one-cycle pulse on a framing violation; reset 0.
- locked  output  1  1 while in RUN state; reset 0.

## Operation
- State machine:
  - HUNT (reset state): samples without sync are dropped.
  - RUN: samples are collected into slots.
- Slot counter: 3 bits, reset 0, wraps 7→0.
- HUNT, in_valid=1, sync=1:
  - sample written to shadow lane 0.
  - slot counter ← 1.
  - go to RUN.
- RUN, in_valid=1, slot≠0, sync=0: sample written to shadow lane[slot], then slot++.
- RUN, in_valid=1, slot=7, sync=0 (frame complete):
  - shadow lanes 0–6 plus the incoming sample are copied to y.
  - out_valid pulses.
  - slot ← 0.
  - stay in RUN.
- RUN, in_valid=1, slot=0:
  - sync=1: normal next frame; write lane 0, slot ← 1.
  - sync=0: frame_err pulses, sample dropped, go to HUNT.
- RUN, in_valid=1, sync=1, slot≠0 (early sync):
  - frame_err pulses and the partial frame is discarded.
  - the sample is taken as the new slot 0 and slot ← 1.
  - stay in RUN.
- in_valid=0: no change in any state. No timeout; gaps of any length are allowed mid-frame.
- y holds its value between frames. A discarded partial frame never reaches y.
- Shadow lanes are not cleared on error. They are overwritten slot by slot, and y is only loaded after all 8 slots are written.

## Timing
- Latency: y and out_valid update on the clock edge that accepts the slot-7 sample. They are visible in the cycle after that sample.
- Back-to-back frames, 8 consecutive valid cycles each, give out_valid once every 8 cycles. Throughput is 1 sample/clock.
- frame_err is registered and asserts in the cycle after the offending sample.
- out_valid and frame_err are never high in the same cycle.
- reset_n low at any time, including mid-frame:
  - all outputs, shadow lanes, slot counter and the error counter clear immediately.
  - state ← HUNT.
  - a frame is resumed only by the first sync after reset release.

## Configuration
- DMX8_ERRCNT_EN defined:
  - adds output port err_cnt, 8 bits, reset 0.
  - err_cnt increments on every frame_err pulse and saturates at 255.
  - err_cnt is cleared only by reset.
- DMX8_ERRCNT_EN undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Package dmx8_pkg holds:
  - NUM_SLOTS = 8 and SLOT_W = 3.
  - the state enum {HUNT, RUN}.
  - ERRCNT_W = 8.
- Sub-module dmx8_slot_dec: 3-to-8 one-hot decoder of the slot counter, gated by the write enable. It drives the shadow-lane write enables and mirrors the transmit-side mux select tree.
- Top level holds the FSM, slot counter, shadow lanes, output register and error logic.

## Test plan
All scenarios use WIDTH=4.

- Reset then one clean frame:
  - stimulus: sync with d_in=0x1, then 0x2…0x8 on consecutive cycles.
  - required: y=0x87654321 and one out_valid pulse the cycle after the 8th sample; locked=1.
- Samples before the first sync: five samples of 0xF with sync=0, then a clean frame 0x0…0x7.
  - required: y=0x76543210, exactly one out_valid, frame_err never asserted.
- Early sync: after 3 samples, sync with 0xA, then 7 more samples 0xB repeated.
  - required: one frame_err pulse, then y=0xBBBBBBBA with one out_valid.
- Missing sync at slot 0: a frame completes, then the next sample has sync=0.
  - required: frame_err pulse, locked→0, y unchanged.
- Gaps: a clean frame with in_valid low for 3 cycles between slots 2 and 3 and between slots 6 and 7.
  - required: same y as with no gaps, out_valid after the last sample.
- Reset mid-frame: reset_n pulsed low after slot 4.
  - required: all outputs 0 and locked=0 immediately.
  - a following clean frame gives the correct y.
  - with DMX8_ERRCNT_EN defined, 300 forced errors give err_cnt=255.
